// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake on both sides.
//
// Logic ops, increment/decrement/negate and add/subtract finish in one cycle.
// Shifts step one bit per cycle for shamt cycles. MUL is shift-add, one
// multiplier bit per cycle, for WIDTH cycles.
//
// Ports:
//   clk        single clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   an operation is offered
//   in_ready   high in IDLE; the operation is taken on in_valid & in_ready
//   op         operation code (0..15)
//   a, b       operands
//   c_in       carry-in for ADD (op 10) and SUB (op 11)
//   shamt      shift amount for ops 12..14
//   out_valid  result and flags are valid (DONE state)
//   out_ready  consumer takes the result on out_valid & out_ready
//   result     operation result, held until the next completion
//   flags      {Z, N, C, V}
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // Working registers. For shifts, work holds the value being shifted; for
  // MUL it is the accumulator, with mcand shifting left and mplier right.
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             sh_c;
  logic [CW-1:0]    cnt;

  // Single-cycle datapath, evaluated directly on the offered inputs.
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_ci;
  logic             use_add;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] lres;
  logic             lc, lv;

  // Multi-cycle step values.
  logic [WIDTH-1:0] sh_nx;
  logic             shc_nx;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] busy_nx;
  logic             busy_c;
  logic             last;
  logic             multi;

  function automatic logic [3:0] mkflags(input logic [WIDTH-1:0] r,
                                         input logic c, input logic v);
    mkflags = {(r == '0), r[WIDTH-1], c, v};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Ops 7..11 all map onto one adder: A-1 is A+all-ones, 0-A is ~A+1.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_ci  = 1'b0;
    use_add = 1'b0;
    lres    = '0;
    unique case (op)
      4'd0:  lres = '0;
      4'd1:  lres = a;
      4'd2:  lres = ~a;
      4'd3:  lres = a & b;
      4'd4:  lres = a | b;
      4'd5:  lres = a ^ b;
      4'd6:  lres = '1;
      4'd7:  begin add_x = a;  add_y = '0; add_ci = 1'b1; use_add = 1'b1; end
      4'd8:  begin add_x = a;  add_y = '1; add_ci = 1'b0; use_add = 1'b1; end
      4'd9:  begin add_x = ~a; add_y = '0; add_ci = 1'b1; use_add = 1'b1; end
      4'd10: begin add_x = a;  add_y = b;  add_ci = c_in; use_add = 1'b1; end
      4'd11: begin add_x = a;  add_y = ~b; add_ci = c_in; use_add = 1'b1; end
      4'd12, 4'd13, 4'd14: lres = a;  // only reached with shamt == 0
      4'd15: lres = '0;               // MUL always goes through BUSY
      default: lres = '0;
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
    lc  = 1'b0;
    lv  = 1'b0;
    if (use_add) begin
      lres = sum[WIDTH-1:0];
      lc   = sum[WIDTH];
      lv   = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
             (sum[WIDTH-1] != add_x[WIDTH-1]);
    end
  end

  // Shifts with a non-zero amount and every MUL need the BUSY state.
  assign multi = (op == 4'd15) || ((op >= 4'd12) && (shamt != '0));

  always_comb begin
    sh_nx  = work;
    shc_nx = sh_c;
    unique case (op_q)
      4'd12: begin sh_nx = {work[WIDTH-2:0], 1'b0};         shc_nx = work[WIDTH-1]; end
      4'd13: begin sh_nx = {1'b0, work[WIDTH-1:1]};         shc_nx = work[0];       end
      4'd14: begin sh_nx = {work[WIDTH-1], work[WIDTH-1:1]}; shc_nx = work[0];       end
      default: begin sh_nx = work; shc_nx = sh_c; end
    endcase
    acc_nx  = work + (mplier[0] ? mcand : '0);
    busy_nx = (op_q == 4'd15) ? acc_nx : sh_nx;
    busy_c  = (op_q == 4'd15) ? 1'b0 : shc_nx;
    last    = (cnt == CW'(1));
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = multi ? BUSY : DONE;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // result/flags load only on the edge that enters DONE, so they hold their
  // previous values through IDLE and BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      work   <= '0;
      mcand  <= '0;
      mplier <= '0;
      sh_c   <= 1'b0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= op;
            if (op == 4'd15) begin
              work   <= '0;
              mcand  <= a;
              mplier <= b;
              cnt    <= CW'(WIDTH);
            end else if (multi) begin
              work <= a;
              sh_c <= 1'b0;
              cnt  <= {1'b0, shamt};
            end else begin
              result <= lres;
              flags  <= mkflags(lres, lc, lv);
            end
          end
        end
        BUSY: begin
          work   <= busy_nx;
          sh_c   <= shc_nx;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - CW'(1);
          if (last) begin
            result <= busy_nx;
            flags  <= mkflags(busy_nx, busy_c, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu at WIDTH=16.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        c_in;
  logic [3:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   ncmp  = 0;
  int   nfail = 0;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .c_in(c_in), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model written from the operation definitions, using wide
  // integer arithmetic rather than a bit-level adder.
  function automatic void model(input logic [3:0] o, input logic [15:0] x, y,
                                input logic ci, input logic [3:0] k,
                                output logic [15:0] r, output logic [3:0] f,
                                output int lat);
    longint ux = x;
    longint uy = y;
    int     sx = $signed(x);
    int     sy = $signed(y);
    int     cii = ci;
    longint us = 0;
    int     ss = 0;
    logic   c = 1'b0;
    logic   v = 1'b0;
    logic   arith = 1'b0;
    r = '0;
    lat = 1;
    case (o)
      4'd0:  r = 16'h0000;
      4'd1:  r = x;
      4'd2:  r = ~x;
      4'd3:  r = x & y;
      4'd4:  r = x | y;
      4'd5:  r = x ^ y;
      4'd6:  r = 16'hFFFF;
      4'd7:  begin us = ux + 1;                     ss = sx + 1;             arith = 1'b1; end
      4'd8:  begin us = ux + 65535;                 ss = sx - 1;             arith = 1'b1; end
      4'd9:  begin us = ((~ux) & 65535) + 1;        ss = -sx;                arith = 1'b1; end
      4'd10: begin us = ux + uy + cii;              ss = sx + sy + cii;      arith = 1'b1; end
      4'd11: begin us = ux + ((~uy) & 65535) + cii; ss = sx - sy - 1 + cii;  arith = 1'b1; end
      4'd12: begin r = x << k; c = (k != 0) ? x[16 - k] : 1'b0; lat = (k != 0) ? k + 1 : 1; end
      4'd13: begin r = x >> k; c = (k != 0) ? x[k - 1] : 1'b0;  lat = (k != 0) ? k + 1 : 1; end
      4'd14: begin r = $signed(x) >>> k; c = (k != 0) ? x[k - 1] : 1'b0; lat = (k != 0) ? k + 1 : 1; end
      4'd15: begin us = (ux * uy) & 65535; r = us[15:0]; lat = 17; end
      default: r = '0;
    endcase
    if (arith) begin
      r = us[15:0];
      c = us[16];
      v = (ss > 32767) || (ss < -32768);
    end
    f = {(r == 16'h0000), r[15], c, v};
  endfunction

  task automatic push(input logic [15:0] r, input logic [3:0] f, input int lat);
    exp_t e;
    e.res = r; e.fl = f; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic push_model(input logic [3:0] o, input logic [15:0] x, y,
                            input logic ci, input logic [3:0] k);
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    model(o, x, y, ci, k, r, f, lat);
    push(r, f, lat);
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] x, y,
                       input logic ci, input logic [3:0] k);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; c_in = ci; shamt = k;
    chk("in_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge. Measures latency, checks the popped
  // expectation, optionally stalls in DONE, then completes the handshake.
  task automatic collect(input string tag, input bit ir_low, input int hold);
    exp_t e;
    int   lat = 1;
    bit   ir_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ir_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    e = q.pop_front();
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_flags"}, flags, e.fl);
    if (ir_low) chk({tag, "_in_ready_busy"}, ir_seen, 1'b0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 4'd6; a = 16'h1111; b = 16'h2222; shamt = 4'd0;
      @(posedge clk);
      #1;
      chk({tag, "_hold_result"}, result, e.res);
      chk({tag, "_hold_flags"}, flags, e.fl);
      chk({tag, "_hold_out_valid"}, out_valid, 1'b1);
      chk({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle_in_ready"}, in_ready, 1'b1);
    chk({tag, "_idle_out_valid"}, out_valid, 1'b0);
    if (hold > 0) begin
      @(posedge clk);
      #1;
      chk({tag, "_no_ghost_op"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] va, vb;
    bit          ov_seen;
    rst_n = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
    c_in = 1'b0; shamt = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", flags, 4'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Release and offer an ADD in the same cycle: first rising edge accepts.
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; op = 4'd10; a = 16'h7FFF; b = 16'h0001; c_in = 1'b0; shamt = 4'd0;
    push(16'h8000, 4'b0101, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    collect("add_ovf", 1'b0, 0);

    push(16'h0000, 4'b1010, 1);
    issue(4'd11, 16'h0005, 16'h0005, 1'b1, 4'd0);
    collect("sub_zero", 1'b0, 0);

    push(16'h0800, 4'b0000, 5);
    issue(4'd13, 16'h8001, 16'h0000, 1'b0, 4'd4);
    collect("shr4", 1'b1, 0);

    push(16'hFFFF, 4'b0100, 16);
    issue(4'd14, 16'h8000, 16'h0000, 1'b0, 4'd15);
    collect("sra15", 1'b1, 0);

    push(16'h03A8, 4'b0000, 17);
    issue(4'd15, 16'h0012, 16'h0034, 1'b0, 4'd0);
    collect("mul", 1'b1, 0);

    // Every opcode on a mixed operand pair.
    va = 16'hA5C3;
    vb = 16'h3C96;
    for (int o = 0; o < 16; o++) begin
      push_model(4'(o), va, vb, o[0], 4'(o));
      issue(4'(o), va, vb, o[0], 4'(o));
      collect($sformatf("op%0d", o), 1'b0, 0);
    end

    // Carry / overflow / zero corners.
    push_model(4'd7, 16'hFFFF, 16'h0000, 1'b0, 4'd0);
    issue(4'd7, 16'hFFFF, 16'h0000, 1'b0, 4'd0);
    collect("inc_wrap", 1'b0, 0);
    push_model(4'd8, 16'h0000, 16'h0000, 1'b0, 4'd0);
    issue(4'd8, 16'h0000, 16'h0000, 1'b0, 4'd0);
    collect("dec_zero", 1'b0, 0);
    push_model(4'd9, 16'h8000, 16'h0000, 1'b0, 4'd0);
    issue(4'd9, 16'h8000, 16'h0000, 1'b0, 4'd0);
    collect("neg_min", 1'b0, 0);
    push_model(4'd9, 16'h0000, 16'h0000, 1'b0, 4'd0);
    issue(4'd9, 16'h0000, 16'h0000, 1'b0, 4'd0);
    collect("neg_zero", 1'b0, 0);
    push_model(4'd12, 16'h8000, 16'h0000, 1'b0, 4'd1);
    issue(4'd12, 16'h8000, 16'h0000, 1'b0, 4'd1);
    collect("shl_out", 1'b0, 0);
    push_model(4'd12, 16'hC001, 16'h0000, 1'b0, 4'd0);
    issue(4'd12, 16'hC001, 16'h0000, 1'b0, 4'd0);
    collect("shl0", 1'b0, 0);
    push_model(4'd15, 16'hFFFF, 16'hFFFF, 1'b0, 4'd0);
    issue(4'd15, 16'hFFFF, 16'hFFFF, 1'b0, 4'd0);
    collect("mul_max", 1'b0, 0);

    // Stall in DONE for 3 cycles with a competing offer present.
    push_model(4'd5, 16'hF0F0, 16'h0FF0, 1'b0, 4'd0);
    issue(4'd5, 16'hF0F0, 16'h0FF0, 1'b0, 4'd0);
    collect("stall", 1'b0, 3);

    // Reset in the 8th BUSY cycle of a MUL: dropped without a result.
    issue(4'd15, 16'h1234, 16'h5678, 1'b0, 4'd0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", result, 16'h0000);
    chk("mid_rst_flags", flags, 4'h0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen = 1'b1;
    end
    chk("mid_rst_no_result", ov_seen, 1'b0);

    push_model(4'd10, 16'h1234, 16'h4321, 1'b1, 4'd0);
    issue(4'd10, 16'h1234, 16'h4321, 1'b1, 4'd0);
    collect("add_after_rst", 1'b0, 0);

    chk("scoreboard_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; legal values are powers of two, 4 to 64.
REQ-002 SHALL have derived parameter SHW = $clog2(WIDTH), default 4, shift-amount width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, an operation is offered.
REQ-006 SHALL have port in_ready, output, 1, the block can accept an operation.
REQ-007 SHALL have port op, input, 4, operation code per REQ-013.
REQ-008 SHALL have ports a and b, input, WIDTH, the operands.
REQ-009 SHALL have port c_in, input, 1, carry-in for ADD and SUB.
REQ-010 SHALL have port shamt, input, SHW, shift amount.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-012 SHALL have ports result (output, WIDTH) and flags (output, 4, {Z,N,C,V}).

Function
REQ-013 Opcodes SHALL be: 0 ZERO; 1 A; 2 ~A; 3 A&B; 4 A|B; 5 A^B; 6 all-ones; 7 A+1; 8 A-1; 9 0-A; 10 A+B+c_in; 11 A+~B+c_in; 12 SHL; 13 SHR logical; 14 SRA arithmetic; 15 MUL, low WIDTH bits of unsigned A*B.
REQ-014 All arithmetic SHALL be modulo 2^WIDTH; carry is bit WIDTH of the (WIDTH+1)-bit sum.
REQ-015 FSM SHALL have states IDLE, BUSY and DONE; in_ready = (state==IDLE).
REQ-016 Accept: in_valid & in_ready at a rising edge latches op, a, b, c_in and shamt; inputs are ignored outside IDLE.
REQ-017 Opcodes 0-11, and 12-14 with shamt=0: IDLE->DONE on the accept edge; out_valid is high the cycle after accept (latency 1).
REQ-018 Opcodes 12-14 with shamt=k>0: IDLE->BUSY; shift one bit per cycle for k cycles; BUSY->DONE on the k-th BUSY edge; latency k+1.
REQ-019 MUL SHALL be shift-add, one multiplier bit per cycle, WIDTH BUSY cycles; latency WIDTH+1.
REQ-020 An internal down-counter of SHW+1 bits SHALL track remaining BUSY cycles.
REQ-021 DONE: out_valid=1; result and flags stay stable until out_valid & out_ready; then DONE->IDLE.
REQ-022 out_ready is ignored outside DONE; no new accept occurs in the handshake cycle (in_ready is 0 in DONE).
REQ-023 Z SHALL be (result==0); N SHALL be result[WIDTH-1].
REQ-024 C SHALL be carry-out for ops 7-11 (op 8 is A+all-ones; op 9 is ~A+1), the last bit shifted out for shifts with shamt>0, and 0 otherwise.
REQ-025 V SHALL be signed overflow for ops 7-11 and 0 otherwise.
REQ-026 While not in DONE, result and flags SHALL hold their last values; out_valid SHALL be 0.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, out_valid=0, result=0, flags=0 and counter=0.
REQ-028 Reset during BUSY or DONE SHALL discard the operation; no out_valid for it after release.
REQ-029 First accept SHALL be possible on the first rising edge with rst_n high.

Verification (WIDTH=16)
REQ-030 op10, a=0x7FFF, b=0x0001, c_in=0 -> result 0x8000, flags Z0 N1 C0 V1, out_valid one cycle after accept.
REQ-031 op11, a=b=0x0005, c_in=1 -> result 0x0000, Z1 N0 C1 V0.
REQ-032 op13, a=0x8001, shamt=4 -> out_valid 5 cycles after accept, result 0x0800, C0; op14, a=0x8000, shamt=15 -> 0xFFFF, N1, C0.
REQ-033 op15, a=0x0012, b=0x0034 -> result 0x03A8, out_valid 17 cycles after accept, in_ready 0 throughout.
REQ-034 out_ready held 0 for 3 cycles in DONE -> result/flags unchanged, in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready 1.
REQ-035 rst_n pulsed low at BUSY cycle 8 of MUL -> outputs 0 asynchronously, IDLE, no out_valid afterward; next ADD completes normally.
